exu_iter_shifter: RTL
=====================

// Module: exu_iter_shifter
// PURPOSE
// - Parametrised multi-cycle shift engine for the EXU. It executes SLL/SRL/SRA for the
//   shift-immediate and shift-register instruction groups.
// - Generalises the single-bit-per-cycle shift loop to XLEN bits and STEP bits per cycle.
// - Gives SRA a true sign-fill, adds a start/busy/done handshake, and adds an abort input.
// - Sits beside the ALU in the EXU. The control FSM stalls ex0 while busy=1.
// PARAMETERS
// - XLEN  32  operand/result width; power of two, >=8
// - STEP  1   bits shifted per iteration; power of two, 1..XLEN
// - SHW   $clog2(XLEN)  shift-amount width (derived, localparam)
// PORTS
// - clk      in   1     rising-edge clock
// - rst      in   1     asynchronous reset, active-low (0 = reset)
// - start    in   1     begin operation; sampled only in IDLE
// - kill     in   1     abort (exception/flush); synchronous
// - op       in   2     00 SLL, 01 SRL, 11 SRA, 10 reserved
// - operand  in   XLEN  value to shift (rs1)
// - shamt    in   SHW   shift amount (shamt or rs2[SHW-1:0])
// - result   out  XLEN  last committed result, held until next commit
// - busy     out  1     1 in SHIFT and DONE states
// - done     out  1     1-cycle pulse, result valid this cycle
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, result=0, busy=0, done=0, internal acc/rem=0.
// - States:
//   - IDLE -> SHIFT on start & !kill & shamt!=0.
//   - IDLE -> DONE on start & !kill & shamt==0.
//   - SHIFT -> DONE when rem<=STEP (last step); else stays in SHIFT.
//   - DONE -> IDLE unconditionally.
// - Start edge E0 (in IDLE): latch acc=operand, rem=shamt, op.
//   - Inputs are don't-care after E0.
// - SHIFT, each edge: shift acc by min(STEP,rem), then rem -= that amount.
//   - SLL fills with 0. SRL fills with 0. SRA fills with acc[XLEN-1] (sign of the original operand).
// - Commit: result <= final acc on the edge entering DONE.
//   - For shamt==0: result <= operand, unchanged.
// - Latency: done is high in cycle 1+ceil(shamt/STEP), where cycle 0 is the start cycle.
//   - shamt==0 gives cycle 1.
// - op=10: treated as SLL by 0. result=operand, latency 1.
// - start while busy: ignored. No queueing, no error.
// - kill, any state: next edge -> IDLE, done=0 that edge, result not updated.
//   - acc/rem are discarded.
// - kill & start together in IDLE: kill wins, nothing starts.
// - kill during DONE: done still pulses (commit already happened); next state is IDLE.
// - Back-to-back: start may be accepted in the cycle after done (IDLE). No bubble beyond DONE.
// - Reset mid-operation: immediate IDLE, result=0, no done.
// - Widths: rem is SHW+1 bits so the step subtract never wraps. shamt >= XLEN cannot occur (SHW bits).
// CONFIGURATION
// - Macro EXU_SHIFT_BARREL_EN:
//   - Defined: a full combinational barrel shifter replaces the loop. STEP is ignored.
//     IDLE -> DONE on every accepted start, SHIFT is unreachable, done is always in cycle 1.
//   - Undefined: iterative datapath as above, minimum area.
//   - All handshake, kill and reset rules are identical in both builds.
// TESTING (XLEN=32; STEP=1 unless noted)
// - T1: SRA operand=0x8000_0000, shamt=4
//   -> result=0xF800_0000, done in cycle 5, busy cycles 1-5.
// - T2: SRL operand=0x8000_0000, shamt=31 -> result=0x0000_0001, done in cycle 32.
//   - Same with STEP=8 -> done in cycle 5.
// - T3: SLL operand=0x1234_5678, shamt=0 -> result=0x1234_5678, done in cycle 1.
//   - A new start in cycle 2 is accepted.
// - T4: SLL operand=0x0000_0001, shamt=16; kill in cycle 3
//   -> no done, IDLE in cycle 4, result keeps its prior value.
//   - Also: start+kill in same IDLE cycle -> busy stays 0.
// - T5: start pulsed in cycle 2 of a running shamt=8 op
//   -> ignored, first op result unchanged, only one done.
//   - Also: rst=0 mid-op -> result=0, busy=0 immediately.
// - T6: build with EXU_SHIFT_BARREL_EN; SRA operand=0xF000_0000, shamt=31
//   -> result=0xFFFF_FFFF, done in cycle 1.

Source files
------------

// File: rtl/exu_iter_shifter.sv
// Multi-cycle SLL/SRL/SRA engine for the EXU. Optional macro EXU_SHIFT_BARREL_EN swaps in a single-cycle barrel shifter.
// Latency: done in cycle 1+ceil(shamt/STEP) after the start cycle (cycle 1 for shamt==0, op=10, or the barrel build).
// Backpressure: none; start is ignored while busy, so the EXU control stalls ex0 on busy.
module exu_iter_shifter #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    kill,
  input  logic [1:0]              op,
  input  logic [XLEN-1:0]         operand,
  input  logic [$clog2(XLEN)-1:0] shamt,
  output logic [XLEN-1:0]         result,
  output logic                    busy,
  output logic                    done
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   start_ok;

  // op=10 falls through to the default arm: the operand is passed unchanged.
  function automatic logic [XLEN-1:0] shift_by(input logic [XLEN-1:0] v,
                                               input logic [1:0]      o,
                                               input logic [SHW:0]    n);
    logic [XLEN-1:0] r;
    case (o)
      2'b00:   r = v << n;
      2'b01:   r = v >> n;
      2'b11:   r = XLEN'($signed(v) >>> n);
      default: r = v;
    endcase
    return r;
  endfunction

  assign start_ok = start & ~kill & (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

`ifdef EXU_SHIFT_BARREL_EN

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (kill) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result <= '0;
    end else if (start_ok) begin
      result <= shift_by(operand, op, {1'b0, shamt});
    end
  end

`else

  localparam logic [SHW:0] STEP_V = (SHW+1)'(STEP);

  logic [XLEN-1:0] acc, acc_step;
  logic [SHW:0]    rem, step_amt;
  logic [1:0]      op_q;
  logic            pass_thru, last_step;

  assign pass_thru = (shamt == '0) | (op == 2'b10);
  assign step_amt  = (rem < STEP_V) ? rem : STEP_V;
  assign last_step = (rem <= STEP_V);
  assign acc_step  = shift_by(acc, op_q, step_amt);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = pass_thru ? S_DONE : S_SHIFT;
      S_SHIFT: if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (kill) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc  <= '0;
      rem  <= '0;
      op_q <= 2'b00;
    end else if (kill) begin
      acc <= '0;
      rem <= '0;
    end else if (start_ok) begin
      acc  <= operand;
      rem  <= {1'b0, shamt};
      op_q <= op;
    end else if (state == S_SHIFT) begin
      acc <= acc_step;
      rem <= rem - step_amt;
    end
  end

  // Commit happens on the edge entering DONE; a kill on that edge drops it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result <= '0;
    end else if (start_ok && pass_thru) begin
      result <= operand;
    end else if (state == S_SHIFT && last_step && !kill) begin
      result <= acc_step;
    end
  end

`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

endmodule
